vga_sync_generator: RTL and testbench

// - Raster timing source for the VGA path: scans 640x480@60 Hz, drives monitor hsync/vsync.
// - Feeds the pixel renderer its pixel coordinates (x_position, y_position) and

---
 rtl/vga_sync_generator_pkg.sv | 43 ++++
 rtl/vga_sync_generator_if.sv | 25 ++
 rtl/vga_sync_generator_clk_enable_divider.sv | 30 +++
 rtl/vga_sync_generator.sv | 114 +++++++++++
 tb/tb_vga_sync_generator.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_generator_pkg.sv
// Shared raster timing for the VGA path: 640x480@60 Hz defaults, derived
// totals and sync window bounds, plus the registered per-pixel output bundle.
package vga_sync_generator_pkg;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
   localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic           hsync;
      logic           vsync;
      logic           inside_video;
      logic [X_W-1:0] x_position;
      logic [Y_W-1:0] y_position;
      logic           line_tick;
      logic           frame_tick;
   } pixel_t;

   // Half-open window test lo <= pos < hi.
   function automatic logic in_window(cnt_t pos, cnt_t lo, cnt_t hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster output bundle: the generator drives it (master), the renderer,
// monitor pins and game core consume it (slave).
interface vga_sync_generator_if;
   import vga_sync_generator_pkg::*;

   logic           pixel_en;
   logic           hsync;
   logic           vsync;
   logic           inside_video;
   logic [X_W-1:0] x_position;
   logic [Y_W-1:0] y_position;
   logic           line_tick;
   logic           frame_tick;

   modport master (
      output pixel_en, hsync, vsync, inside_video,
             x_position, y_position, line_tick, frame_tick
   );

   modport slave (
      input  pixel_en, hsync, vsync, inside_video,
             x_position, y_position, line_tick, frame_tick
   );

endinterface

// File: rtl/vga_sync_generator_clk_enable_divider.sv
// Pixel-rate enable: d counts 0..CLK_DIV-1 and strobe marks the last count.
// With CLK_DIV=1 the counter never leaves 0, so strobe is constantly high.
module clk_enable_divider #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic strobe
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   typedef logic [DW-1:0] div_t;
   localparam div_t D_LAST = div_t'(CLK_DIV - 1);

   div_t d;

   assign strobe = (d == D_LAST);

   // Free-running divider, wraps after the strobe count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d <= '0;
      end else if (d == D_LAST) begin
         d <= '0;
      end else begin
         d <= d + div_t'(1);
      end
   end

endmodule

// File: rtl/vga_sync_generator.sv
// Raster timing source: h/v scan counters advanced at the pixel rate, with
// every output registered from the position the counters are about to load,
// so outputs and counters change together on each pixel strobe.
module vga_sync_generator
   import vga_sync_generator_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   vga_sync_generator_if.master vga
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
   localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
   localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
   localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
   localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam pixel_t PX_RESET = '{
      hsync:        ~SYNC_POL,
      vsync:        ~SYNC_POL,
      inside_video: 1'b0,
      x_position:   '0,
      y_position:   '0,
      line_tick:    1'b0,
      frame_tick:   1'b0
   };

   logic   s;
   cnt_t   h;
   cnt_t   v;
   cnt_t   h_nxt;
   cnt_t   v_nxt;
   logic   vis_nxt;
   logic   pixel_en_q;
   pixel_t px_q;
   pixel_t px_nxt;

   clk_enable_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .strobe (s)
   );

   // Next raster position: h wraps at line end and carries into v.
   always_comb begin
      h_nxt = h + cnt_t'(1);
      v_nxt = v;
      if (h == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v == V_LAST) ? '0 : v + cnt_t'(1);
      end
   end

   // Output decode for the position about to be loaded.
   always_comb begin
      vis_nxt             = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      px_nxt.hsync        = in_window(h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      px_nxt.vsync        = in_window(v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      px_nxt.inside_video = vis_nxt;
      px_nxt.x_position   = vis_nxt ? h_nxt[X_W-1:0] : '0;
      px_nxt.y_position   = vis_nxt ? v_nxt[Y_W-1:0] : '0;
      px_nxt.line_tick    = (h_nxt == '0);
      px_nxt.frame_tick   = (h_nxt == '0) && (v_nxt == V_VIS);
   end

   // Counters and output registers; ticks last only the clk after a strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h          <= H_LAST;
         v          <= V_LAST;
         pixel_en_q <= 1'b0;
         px_q       <= PX_RESET;
      end else begin
         pixel_en_q <= s;
         if (s) begin
            h    <= h_nxt;
            v    <= v_nxt;
            px_q <= px_nxt;
         end else begin
            px_q.line_tick  <= 1'b0;
            px_q.frame_tick <= 1'b0;
         end
      end
   end

   assign vga.pixel_en     = pixel_en_q;
   assign vga.hsync        = px_q.hsync;
   assign vga.vsync        = px_q.vsync;
   assign vga.inside_video = px_q.inside_video;
   assign vga.x_position   = px_q.x_position;
   assign vga.y_position   = px_q.y_position;
   assign vga.line_tick    = px_q.line_tick;
   assign vga.frame_tick   = px_q.frame_tick;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: three instances (small raster CLK_DIV=2,
// small raster CLK_DIV=1 with active-high sync, full 640x480 CLK_DIV=2)
// checked every cycle against a time-based raster model, plus literal
// expectations at start-up, mid-line reset and line/frame periods.
module tb_vga_sync_generator;

   localparam int SH_V = 16, SH_F = 4, SH_S = 6, SH_B = 4;
   localparam int SV_V = 8,  SV_F = 2, SV_S = 2, SV_B = 3;

   typedef struct packed {
      logic       pe;
      logic       hs;
      logic       vs;
      logic       iv;
      logic [9:0] x;
      logic [8:0] y;
      logic       lt;
      logic       ft;
   } obs_t;

   logic clk;
   logic rst;
   int   e   = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   vga_sync_generator_if if_a ();
   vga_sync_generator_if if_b ();
   vga_sync_generator_if if_c ();

   vga_sync_generator #(
      .CLK_DIV (2), .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
      .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B), .SYNC_POL (1'b0)
   ) dut_a (.clk (clk), .rst (rst), .vga (if_a));

   vga_sync_generator #(
      .CLK_DIV (1), .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
      .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B), .SYNC_POL (1'b1)
   ) dut_b (.clk (clk), .rst (rst), .vga (if_b));

   vga_sync_generator #(
      .CLK_DIV (2)
   ) dut_c (.clk (clk), .rst (rst), .vga (if_c));

   obs_t act_a, act_b, act_c;
   assign act_a = {if_a.pixel_en, if_a.hsync, if_a.vsync, if_a.inside_video,
                   if_a.x_position, if_a.y_position, if_a.line_tick, if_a.frame_tick};
   assign act_b = {if_b.pixel_en, if_b.hsync, if_b.vsync, if_b.inside_video,
                   if_b.x_position, if_b.y_position, if_b.line_tick, if_b.frame_tick};
   assign act_c = {if_c.pixel_en, if_c.hsync, if_c.vsync, if_c.inside_video,
                   if_c.x_position, if_c.y_position, if_c.line_tick, if_c.frame_tick};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global clock count for period measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Clock edges since reset release; drives the raster model.
   always @(posedge clk or posedge rst) begin
      if (rst) e <= 0;
      else     e <= e + 1;
   end

   // Expected outputs after e clk edges since release: pixel slot k = e/div - 1.
   function automatic obs_t model(int ec, logic r, int div, int hv, int hf, int hs, int hb,
                                  int vv, int vf, int vs, int vb, logic pol);
      obs_t o;
      int   ht, vt, k, h, v;
      o    = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      if (r || ec == 0) return o;
      o.pe = (ec % div == 0);
      if (ec / div == 0) return o;
      ht   = hv + hf + hs + hb;
      vt   = vv + vf + vs + vb;
      k    = ec / div - 1;
      h    = k % ht;
      v    = (k / ht) % vt;
      o.iv = (h < hv) && (v < vv);
      o.hs = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
      o.vs = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
      o.x  = o.iv ? 10'(h) : '0;
      o.y  = o.iv ? 9'(v) : '0;
      o.lt = o.pe && (h == 0);
      o.ft = o.pe && (h == 0) && (v == vv);
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("pe=%0b hs=%0b vs=%0b iv=%0b x=%0d y=%0d lt=%0b ft=%0b",
                       o.pe, o.hs, o.vs, o.iv, o.x, o.y, o.lt, o.ft);
   endfunction

   task automatic cmp(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // First two edges after release, sampled #1 after each edge.
   task automatic start_checks();
      @(posedge clk); #1;
      check_int("a_e1_pe", int'(if_a.pixel_en), 0);
      check_int("a_e1_iv", int'(if_a.inside_video), 0);
      check_int("a_e1_lt", int'(if_a.line_tick), 0);
      check_int("b_e1_pe", int'(if_b.pixel_en), 1);
      check_int("b_e1_iv", int'(if_b.inside_video), 1);
      check_int("b_e1_x", int'(if_b.x_position), 0);
      check_int("b_e1_lt", int'(if_b.line_tick), 1);
      check_int("c_e1_pe", int'(if_c.pixel_en), 0);
      @(posedge clk); #1;
      cmp("a_e2", act_a, '{pe: 1'b1, hs: 1'b1, vs: 1'b1, iv: 1'b1, x: 10'd0, y: 9'd0, lt: 1'b1, ft: 1'b0});
      check_int("b_e2_x", int'(if_b.x_position), 1);
      check_int("b_e2_lt", int'(if_b.line_tick), 0);
      check_int("b_e2_pe", int'(if_b.pixel_en), 1);
      cmp("c_e2", act_c, '{pe: 1'b1, hs: 1'b1, vs: 1'b1, iv: 1'b1, x: 10'd0, y: 9'd0, lt: 1'b1, ft: 1'b0});
   endtask

   // Per-cycle comparison of all instances against the raster model.
   initial begin
      forever begin
         @(negedge clk);
         cmp("a_cycle", act_a, model(e, rst, 2, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 1'b0));
         cmp("b_cycle", act_b, model(e, rst, 1, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 1'b1));
         cmp("c_cycle", act_c, model(e, rst, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      end
   end

   // Full-size line: period, visible width and hsync window.
   initial begin
      int last_lt, slot, vis, hsn, hs_first, hs_last;
      last_lt = -1; slot = -1; vis = 0; hsn = 0; hs_first = -1; hs_last = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_lt = -1;
            slot    = -1;
         end else if (if_c.pixel_en) begin
            if (if_c.line_tick) begin
               if (last_lt >= 0) begin
                  check_int("c_line_period", cyc - last_lt, 1600);
                  check_int("c_visible_px", vis, 640);
                  check_int("c_hsync_px", hsn, 96);
                  check_int("c_hsync_first", hs_first, 656);
                  check_int("c_hsync_last", hs_last, 751);
               end
               last_lt = cyc; slot = 0; vis = 0; hsn = 0; hs_first = -1; hs_last = -1;
            end else if (slot >= 0) begin
               slot++;
            end
            if (slot >= 0) begin
               if (if_c.inside_video) vis++;
               if (!if_c.hsync) begin
                  hsn++;
                  if (hs_first < 0) hs_first = slot;
                  hs_last = slot;
               end
            end
         end
      end
   end

   // Small raster, CLK_DIV=2: frame period, lines per frame, vsync lines.
   initial begin
      int last_ft, lines, vs_lines;
      last_ft = -1; lines = 0; vs_lines = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_ft = -1; lines = 0; vs_lines = 0;
         end else if (if_a.pixel_en) begin
            if (if_a.line_tick) begin
               lines++;
               if (!if_a.vsync) vs_lines++;
            end
            if (if_a.frame_tick) begin
               check_int("a_ft_iv", int'(if_a.inside_video), 0);
               check_int("a_ft_y", int'(if_a.y_position), 0);
               if (last_ft >= 0) begin
                  check_int("a_frame_period", cyc - last_ft, 900);
                  check_int("a_lines_per_frame", lines, 15);
                  check_int("a_vsync_lines", vs_lines, 2);
               end
               last_ft = cyc; lines = 0; vs_lines = 0;
            end
         end
      end
   end

   // Small raster, CLK_DIV=1, active-high sync: hsync/vsync periods and width.
   initial begin
      int   last_hr, last_vr;
      logic prev_hs, prev_vs;
      last_hr = -1; last_vr = -1; prev_hs = 1'b0; prev_vs = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_hr = -1; last_vr = -1;
         end else begin
            if (if_b.hsync && !prev_hs) begin
               if (last_hr >= 0) check_int("b_hsync_period", cyc - last_hr, 30);
               last_hr = cyc;
            end
            if (!if_b.hsync && prev_hs && last_hr >= 0)
               check_int("b_hsync_width", cyc - last_hr, 6);
            if (if_b.vsync && !prev_vs) begin
               if (last_vr >= 0) check_int("b_vsync_period", cyc - last_vr, 450);
               last_vr = cyc;
            end
         end
         prev_hs = if_b.hsync;
         prev_vs = if_b.vsync;
      end
   end

   // Directed sequence: reset, start-up, mid-line reset, restart.
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      start_checks();

      for (int i = 0; i < 5000 && e < 2202; i++) begin
         @(posedge clk); #1;
      end
      check_int("c_reach_h300", e, 2202);
      #1;
      cmp("c_h300_v1", act_c, '{pe: 1'b1, hs: 1'b1, vs: 1'b1, iv: 1'b1, x: 10'd300, y: 9'd1, lt: 1'b0, ft: 1'b0});

      rst = 1'b1;
      #1;
      cmp("a_async_rst", act_a, '{pe: 1'b0, hs: 1'b1, vs: 1'b1, iv: 1'b0, x: 10'd0, y: 9'd0, lt: 1'b0, ft: 1'b0});
      cmp("b_async_rst", act_b, '{pe: 1'b0, hs: 1'b0, vs: 1'b0, iv: 1'b0, x: 10'd0, y: 9'd0, lt: 1'b0, ft: 1'b0});
      cmp("c_async_rst", act_c, '{pe: 1'b0, hs: 1'b1, vs: 1'b1, iv: 1'b0, x: 10'd0, y: 9'd0, lt: 1'b0, ft: 1'b0});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      start_checks();

      repeat (3400) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
